cnn_concat_scheduler: RTL and testbench

Segment scheduler for the five-input channel-concatenation stage of the decoder. It drains each of five producer streams in fixed order (no1 → no5), one complete segment per input, through a valid/ready handshake. The merged stream goes out on one registered output. It replaces deep delay-line alignment: a producer is stalled until its segment is due. It sits between the ASPP/skip branch producers and the following 1x1 convolution.

---
 rtl/cnn_concat_scheduler_if.sv | 37 +++
 rtl/cnn_concat_scheduler.sv | 140 ++++++++++++++
 tb/tb_cnn_concat_scheduler.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_concat_scheduler_if.sv
// Producer-side and merged-output handshake bundle for cnn_concat_scheduler.
// master: producers + downstream consumer side; slave: the scheduler.
interface cnn_concat_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid_in_no1;
  logic                  valid_in_no2;
  logic                  valid_in_no3;
  logic                  valid_in_no4;
  logic                  valid_in_no5;
  logic [DATA_WIDTH-1:0] in_no1;
  logic [DATA_WIDTH-1:0] in_no2;
  logic [DATA_WIDTH-1:0] in_no3;
  logic [DATA_WIDTH-1:0] in_no4;
  logic [DATA_WIDTH-1:0] in_no5;
  logic                  ready_no1;
  logic                  ready_no2;
  logic                  ready_no3;
  logic                  ready_no4;
  logic                  ready_no5;
  logic [DATA_WIDTH-1:0] out;
  logic                  valid_out;

  modport master (
    output valid_in_no1, valid_in_no2, valid_in_no3, valid_in_no4, valid_in_no5,
    output in_no1, in_no2, in_no3, in_no4, in_no5,
    input  ready_no1, ready_no2, ready_no3, ready_no4, ready_no5,
    input  out, valid_out
  );

  modport slave (
    input  valid_in_no1, valid_in_no2, valid_in_no3, valid_in_no4, valid_in_no5,
    input  in_no1, in_no2, in_no3, in_no4, in_no5,
    output ready_no1, ready_no2, ready_no3, ready_no4, ready_no5,
    output out, valid_out
  );
endinterface

// File: rtl/cnn_concat_scheduler.sv
// Five-input channel-concat segment scheduler: drains producer 1..5 in order,
// one segment each, onto a single registered output stream.
// Optional feature: define CNN_CONCAT_FRAME_CNT_EN to add a 16-bit frame_cnt output.
module cnn_concat_scheduler #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 24,
  parameter int unsigned SEG_LEN_1  = 16384,
  parameter int unsigned SEG_LEN_2  = 16384,
  parameter int unsigned SEG_LEN_3  = 16384,
  parameter int unsigned SEG_LEN_4  = 16384,
  parameter int unsigned SEG_LEN_5  = 16384
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  cnn_concat_scheduler_if.slave      bus,
  output logic [2:0]                 seg_sel,
  output logic                       busy,
`ifdef CNN_CONCAT_FRAME_CNT_EN
  output logic [15:0]                frame_cnt,
`endif
  output logic                       frame_done
);

  localparam logic [CNT_WIDTH-1:0] LAST_1 = CNT_WIDTH'(SEG_LEN_1 - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_2 = CNT_WIDTH'(SEG_LEN_2 - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_3 = CNT_WIDTH'(SEG_LEN_3 - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_4 = CNT_WIDTH'(SEG_LEN_4 - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_5 = CNT_WIDTH'(SEG_LEN_5 - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEG1 = 3'd1,
    SEG2 = 3'd2,
    SEG3 = 3'd3,
    SEG4 = 3'd4,
    SEG5 = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  frame_done_q, frame_done_d;

  logic                  sel_vld;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic [CNT_WIDTH-1:0]  sel_last;

  // Ready depends only on the state register so producers never see a valid->ready loop.
  assign bus.ready_no1 = (state_q == SEG1);
  assign bus.ready_no2 = (state_q == SEG2);
  assign bus.ready_no3 = (state_q == SEG3);
  assign bus.ready_no4 = (state_q == SEG4);
  assign bus.ready_no5 = (state_q == SEG5);

  assign seg_sel       = 3'(state_q);
  assign busy          = (state_q != IDLE);
  assign bus.out       = out_q;
  assign bus.valid_out = valid_out_q;
  assign frame_done    = frame_done_q;

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_d        = out_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    sel_vld      = 1'b0;
    sel_dat      = '0;
    sel_last     = '0;

    case (state_q)
      SEG1: begin sel_vld = bus.valid_in_no1; sel_dat = bus.in_no1; sel_last = LAST_1; end
      SEG2: begin sel_vld = bus.valid_in_no2; sel_dat = bus.in_no2; sel_last = LAST_2; end
      SEG3: begin sel_vld = bus.valid_in_no3; sel_dat = bus.in_no3; sel_last = LAST_3; end
      SEG4: begin sel_vld = bus.valid_in_no4; sel_dat = bus.in_no4; sel_last = LAST_4; end
      SEG5: begin sel_vld = bus.valid_in_no5; sel_dat = bus.in_no5; sel_last = LAST_5; end
      default: ;
    endcase

    if (state_q == IDLE) begin
      if (start) begin
        state_d = SEG1;
        cnt_d   = '0;
      end
    end else if (sel_vld) begin
      out_d       = sel_dat;
      valid_out_d = 1'b1;
      if (cnt_q == sel_last) begin
        cnt_d = '0;
        if (state_q == SEG5) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          state_d = state_t'(3'(state_q) + 3'd1);
        end
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      out_q        <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef CNN_CONCAT_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt = frame_cnt_q;

  // Completed-frame counter, wraps naturally at 16 bits.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_done_d) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  // Frame counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end
`endif

endmodule

// File: tb/tb_cnn_concat_scheduler.sv
// Directed bench for cnn_concat_scheduler with SEG_LEN = 3,2,1,2,4.
// Each producer emits {producer number, per-producer beat index}.
module tb_cnn_concat_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  vld;
  logic [2:0]  seg_sel;
  logic        busy;
  logic        frame_done;
`ifdef CNN_CONCAT_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int unsigned pcnt [5];
  int          exp_n [5];
  int          seq [12] = '{0, 0, 0, 1, 1, 2, 3, 3, 4, 4, 4, 4};
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  cnn_concat_scheduler_if #(.DATA_WIDTH(32)) bus ();

  assign bus.valid_in_no1 = vld[0];
  assign bus.valid_in_no2 = vld[1];
  assign bus.valid_in_no3 = vld[2];
  assign bus.valid_in_no4 = vld[3];
  assign bus.valid_in_no5 = vld[4];
  assign bus.in_no1 = {16'd1, 16'(pcnt[0])};
  assign bus.in_no2 = {16'd2, 16'(pcnt[1])};
  assign bus.in_no3 = {16'd3, 16'(pcnt[2])};
  assign bus.in_no4 = {16'd4, 16'(pcnt[3])};
  assign bus.in_no5 = {16'd5, 16'(pcnt[4])};

  // Producers advance their sample index on each accepted handshake.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt[0] <= 0; pcnt[1] <= 0; pcnt[2] <= 0; pcnt[3] <= 0; pcnt[4] <= 0;
    end else begin
      if (bus.valid_in_no1 && bus.ready_no1) pcnt[0] <= pcnt[0] + 1;
      if (bus.valid_in_no2 && bus.ready_no2) pcnt[1] <= pcnt[1] + 1;
      if (bus.valid_in_no3 && bus.ready_no3) pcnt[2] <= pcnt[2] + 1;
      if (bus.valid_in_no4 && bus.ready_no4) pcnt[3] <= pcnt[3] + 1;
      if (bus.valid_in_no5 && bus.ready_no5) pcnt[4] <= pcnt[4] + 1;
    end
  end

  cnn_concat_scheduler #(
    .DATA_WIDTH(32),
    .CNT_WIDTH (24),
    .SEG_LEN_1 (3),
    .SEG_LEN_2 (2),
    .SEG_LEN_3 (1),
    .SEG_LEN_4 (2),
    .SEG_LEN_5 (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .seg_sel   (seg_sel),
    .busy      (busy),
`ifdef CNN_CONCAT_FRAME_CNT_EN
    .frame_cnt (frame_cnt),
`endif
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'({bus.ready_no5, bus.ready_no4, bus.ready_no3,
                                bus.ready_no2, bus.ready_no1}), 32'd0);
    check({tag, "_seg_sel"}, 32'(seg_sel), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid_out"}, 32'(bus.valid_out), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 5; i++) exp_n[i] = 0;
  endtask

  // Called right after a negedge; start is sampled on the following posedge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ready_no1", 32'(bus.ready_no1), 32'd1);
    check("start_seg_sel", 32'(seg_sel), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
  endtask

  // Follows one frame from the SEG1 cycle until its 12th output beat.
  task automatic expect_frame(input int exp_cycles, input int stall2,
                              input int mid_start, input bit restart);
    int beat = 0;
    int cyc  = 0;
    int fd   = 0;
    int st   = 0;
    int k;
    while (beat < 12 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (frame_done) fd++;
      if (bus.valid_out) begin
        k = seq[beat];
        check("beat_data", bus.out, {16'(k + 1), 16'(exp_n[k])});
        exp_n[k]++;
        check("frame_done_pos", 32'(frame_done), 32'(beat == 11));
        if (beat == 11) check("busy_at_done", 32'(busy), 32'd0);
        beat++;
      end
      if (stall2 > 0 && seg_sel == 3'd2 && !vld[1]) begin
        check("ready_no2_stall", 32'(bus.ready_no2), 32'd1);
        st++;
        if (st > stall2) vld[1] = 1'b1;
      end
      if (cyc == mid_start) start = 1'b1;
      if (restart && frame_done) start = 1'b1;
    end
    check("frame_beats", 32'(beat), 32'd12);
    check("frame_cycles", 32'(cyc), 32'(exp_cycles));
    check("frame_done_count", 32'(fd), 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    vld   = 5'b11111;
    clear_model();
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_out", bus.out, 32'd0);
`ifdef CNN_CONCAT_FRAME_CNT_EN
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // All producers valid while idle: nothing is accepted.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle_outputs("idle_valids");
    end

    // Plain frame: 12 back-to-back beats.
    pulse_start();
    expect_frame(12, 0, 0, 1'b0);

    // Producer 2 stalls 5 cycles at the start of its segment.
    vld[1] = 1'b0;
    pulse_start();
    expect_frame(17, 5, 0, 1'b0);
    check("stall_vld2_restored", 32'(vld[1]), 32'd1);

    // start during a frame is ignored and not queued.
    pulse_start();
    expect_frame(12, 0, 5, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("no_queued_start_busy", 32'(busy), 32'd0);
      check("no_queued_start_vout", 32'(bus.valid_out), 32'd0);
    end

    // Reset during SEG3 discards the frame.
    pulse_start();
    n = 0;
    while (seg_sel != 3'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reached_seg3", 32'(seg_sel), 32'd3);
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    check("mid_reset_out", bus.out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    repeat (3) begin
      @(negedge clk);
      check("post_reset_frame_done", 32'(frame_done), 32'd0);
      check("post_reset_busy", 32'(busy), 32'd0);
    end
    pulse_start();
    expect_frame(12, 0, 0, 1'b0);

    // Restart in the frame_done cycle: two frames, two frame_done pulses.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    pulse_start();
    expect_frame(12, 0, 0, 1'b1);
    check("restart_start_seen", 32'(start), 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("restart_seg_sel", 32'(seg_sel), 32'd1);
    expect_frame(12, 0, 0, 1'b0);
`ifdef CNN_CONCAT_FRAME_CNT_EN
    check("frame_cnt_two", 32'(frame_cnt), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
